seven_segment_scan_controller: RTL and testbench

Time-multiplexed scan controller for the 4-digit MM:SS seven-segment display. It shares a single `SevenSegmentsDecoder` between the four BCD digits, cycling one digit at a time with a blanking gap between digits to suppress ghosting. It sits between the time-keeping counters and the board's shared segment bus and common-anode enables, replacing one-decoder-per-digit direct drive.

---
 rtl/seven_segment_scan_controller_pkg.sv | 19 +
 rtl/seven_segment_scan_controller_dec.sv | 25 ++
 rtl/seven_segment_scan_controller.sv | 126 ++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared definitions for the MM:SS seven-segment scan controller:
// FSM encoding, digit slot indices and segment constants.
package seven_segment_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    localparam logic [1:0] DIG_SU = 2'd0;
    localparam logic [1:0] DIG_ST = 2'd1;
    localparam logic [1:0] DIG_MU = 2'd2;
    localparam logic [1:0] DIG_MT = 2'd3;

    localparam logic [6:0] SEG_OFF_DEFAULT = 7'b1111111;
    localparam logic [3:0] BCD_MAX         = 4'd9;

endpackage

// File: rtl/seven_segment_scan_controller_dec.sv
// BCD to active-low seven-segment decoder, bit0 = segment a ... bit6 = segment g.
// Codes above 9 produce an all-dark pattern.
module SevenSegmentsDecoder (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        unique case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed 4-digit scan: one shared decoder, a blank gap before every
// digit, and a per-frame snapshot so a frame never mixes two different times.
module seven_segment_scan_controller
    import seven_segment_scan_controller_pkg::*;
#(
    parameter int         DIGIT_TICKS = 50000,
    parameter int         BLANK_TICKS = 500,
    parameter logic [6:0] SEG_OFF     = SEG_OFF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       blank_leading_zero,
    input  logic [3:0] second_unit,
    input  logic [3:0] second_tens,
    input  logic [3:0] minute_unit,
    input  logic [3:0] minute_tens,
    output logic [6:0] seg_out,
    output logic [3:0] digit_en,
    output logic       frame_done
);

    localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS) + 1;
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      snap_q, snap_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       en_q, en_d;
    logic             fd_q, fd_d;

    logic [3:0] cur_bcd;
    logic [6:0] dec_seg;
    logic       lz_blank;

    // idx only moves on SHOW exit, so idx_q already names the slot being entered
    assign cur_bcd  = snap_q[{idx_q, 2'b00} +: 4];
    assign lz_blank = blank_leading_zero && (snap_q[15:12] == 4'd0);

    SevenSegmentsDecoder u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        unique case (state_q)
            IDLE: begin
                idx_d = DIG_SU;
                cnt_d = '0;
                if (enable) state_d = BLANK;
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == DIGIT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            idx_d   = DIG_SU;
            cnt_d   = '0;
        end

        if (state_d == BLANK && state_q != BLANK && idx_d == DIG_SU)
            snap_d = {minute_tens, minute_unit, second_tens, second_unit};

        // Outputs follow the next state so they land on the same edge as it
        en_d = 4'b1111;
        seg_d = SEG_OFF;
        fd_d = 1'b0;
        if (state_d == SHOW) begin
            fd_d = (idx_d == DIG_MT) && (cnt_d == DIGIT_LAST);
            if (!(idx_d == DIG_MT && lz_blank)) begin
                en_d[idx_d] = 1'b0;
                seg_d = (cur_bcd > BCD_MAX) ? SEG_OFF : dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= DIG_SU;
            cnt_q   <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_OFF;
            en_q    <= 4'b1111;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            en_q    <= en_d;
            fd_q    <= fd_d;
        end
    end

    assign seg_out    = seg_q;
    assign digit_en   = en_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: a frame-position reference model pushes the expected
// outputs each edge; a monitor pops and compares them on the falling edge.
module tb_seven_segment_scan_controller;

    localparam int D = 4;
    localparam int B = 1;
    localparam int SLOT = B + D;
    localparam int P = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       blank_leading_zero = 1'b0;
    logic [3:0] second_unit = 4'd0, second_tens = 4'd0, minute_unit = 4'd0, minute_tens = 4'd0;
    logic [6:0] seg_out;
    logic [3:0] digit_en;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] en;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    // lit segments, active-high, bit0 = a
    logic [6:0] lit_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seven_segment_scan_controller #(
        .DIGIT_TICKS (D),
        .BLANK_TICKS (B),
        .SEG_OFF     (7'b1111111)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .blank_leading_zero (blank_leading_zero),
        .second_unit        (second_unit),
        .second_tens        (second_tens),
        .minute_unit        (minute_unit),
        .minute_tens        (minute_tens),
        .seg_out            (seg_out),
        .digit_en           (digit_en),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: position within the running frame decides everything
    initial begin
        bit      running;
        int      pos;
        int      snap [4];
        exp_t    e;
        running = 0;
        pos = 0;
        forever begin
            @(posedge clk);
            e.seg = 7'h7F;
            e.en  = 4'hF;
            e.fd  = 1'b0;
            if (!rst_n || !enable) begin
                running = 0;
            end else begin
                int f, slot, w;
                if (!running) begin
                    running = 1;
                    pos = 0;
                end else begin
                    pos++;
                end
                f = pos % P;
                if (f == 0) begin
                    snap[0] = int'(second_unit);
                    snap[1] = int'(second_tens);
                    snap[2] = int'(minute_unit);
                    snap[3] = int'(minute_tens);
                end
                slot = f / SLOT;
                w    = f % SLOT;
                e.fd = (f == P - 1);
                if (w >= B && !(slot == 3 && blank_leading_zero && snap[3] == 0)) begin
                    e.en = ~(4'b0001 << slot);
                    if (snap[slot] <= 9) e.seg = ~lit_tbl[snap[slot]];
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (seg_out !== e.seg) begin
                    bad++;
                    $display("FAIL seg_out t=%0t got=%b want=%b", $time, seg_out, e.seg);
                end
                total++;
                if (digit_en !== e.en) begin
                    bad++;
                    $display("FAIL digit_en t=%0t got=%b want=%b", $time, digit_en, e.en);
                end
                total++;
                if (frame_done !== e.fd) begin
                    bad++;
                    $display("FAIL frame_done t=%0t got=%b want=%b", $time, frame_done, e.fd);
                end
                total++;
                if ($countones(~digit_en) > 1) begin
                    bad++;
                    $display("FAIL enable_onehot t=%0t got=%b want=at_most_one_low", $time, digit_en);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_en(input logic [3:0] pat);
        int k;
        k = 0;
        while (digit_en !== pat && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (digit_en !== pat) begin
            bad++;
            $display("FAIL wait_digit_en got=%b want=%b", digit_en, pat);
        end
    endtask

    task automatic set_digits(input logic [3:0] su, st, mu, mt);
        second_unit = su;
        second_tens = st;
        minute_unit = mu;
        minute_tens = mt;
    endtask

    initial begin
        // reset held with enable high
        enable = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        cycles(3);
        rst_n = 1'b1;

        // basic scan
        cycles(45);

        // snapshot: change minute_tens mid-frame
        wait_en(4'b1101);
        minute_tens = 4'd7;
        cycles(45);

        // leading zero suppressed, then shown
        enable = 1'b0;
        cycles(2);
        minute_tens = 4'd0;
        blank_leading_zero = 1'b1;
        enable = 1'b1;
        cycles(45);
        enable = 1'b0;
        cycles(2);
        blank_leading_zero = 1'b0;
        enable = 1'b1;
        cycles(45);

        // invalid BCD on slot 0
        enable = 1'b0;
        cycles(2);
        set_digits(4'hC, 4'd5, 4'd9, 4'd8);
        enable = 1'b1;
        cycles(25);

        // abort during idx=2 SHOW and restart
        wait_en(4'b1011);
        cycles(1);
        enable = 1'b0;
        cycles(3);
        enable = 1'b1;
        cycles(25);

        // randomized traffic including enable drops and resets
        for (int i = 0; i < 600; i++) begin
            set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            enable = ($urandom_range(0, 39) != 0);
            rst_n  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 49) == 0) blank_leading_zero = ~blank_leading_zero;
            cycles(1);
        end
        rst_n = 1'b1;
        enable = 1'b1;
        cycles(3);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
